// File: rtl/msu_pkg.sv
// msu_pkg: shared types and defaults for the MSU sector-read arbiter.
//   arb_state_t : arbiter FSM states (ST_TMO only reachable with MSU_ARB_TIMEOUT_EN)
//   OWN_AUD/OWN_DAT : owner encoding, also the bit index of each requester in reqs
package msu_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_XFER, ST_DONE, ST_TMO} arb_state_t;

  localparam logic OWN_AUD = 1'b0;
  localparam logic OWN_DAT = 1'b1;

  localparam int MSU_SECTOR_WORDS = 256;
  localparam int MSU_LBA_W        = 21;
endpackage

// File: rtl/msu_rr_pick.sv
// msu_rr_pick: combinational 2-way picker with audio-urgent override.
//   reqs   in  2  request bits, indexed by owner code
//   urgent in  1  audio FIFO below low watermark
//   last   in  1  owner served most recently
//   winner out 1  owner to grant (only meaningful when any req is high)
module msu_rr_pick
  import msu_pkg::*;
(
  input  logic [1:0] reqs,
  input  logic       urgent,
  input  logic       last,
  output logic       winner
);
  always_comb begin
    winner = ~last;  // both requesting: alternate away from the last owner
    if (urgent && reqs[OWN_AUD])
      winner = OWN_AUD;
    else if (reqs[OWN_AUD] && !reqs[OWN_DAT])
      winner = OWN_AUD;
    else if (reqs[OWN_DAT] && !reqs[OWN_AUD])
      winner = OWN_DAT;
  end
endmodule

// File: rtl/msu_sd_arbiter.sv
// msu_sd_arbiter: shares the HPS sector-read slot between the MSU audio
// streamer and the MSU data-port reader, one 512-byte sector at a time.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   aud_req/aud_lba               audio request (level, held until aud_done) + sector
//   aud_gnt/aud_ack/aud_wr/aud_done  audio grant, gated sd_ack/sd_buff_wr, end pulse
//   dat_*                         same set for the data reader
//   audio_fifo_usedw              audio FIFO level; below AUD_LOW_WM audio wins
//   sd_lba/sd_rd                  request to HPS
//   sd_ack/sd_buff_wr             HPS transfer-active and word strobe
//   xfer_words                    words counted in the last completed transfer
//   short_xfer                    sticky: some transfer ended with != SECTOR_WORDS words
// Optional: define MSU_ARB_TIMEOUT_EN to abort ISSUE after ACK_TIMEOUT cycles
// without sd_ack; adds parameter ACK_TIMEOUT and output arb_timeout.
module msu_sd_arbiter
  import msu_pkg::*;
#(
  parameter int LBA_W        = MSU_LBA_W,
  parameter int SECTOR_WORDS = MSU_SECTOR_WORDS,
  parameter int AUD_LOW_WM   = 1024
`ifdef MSU_ARB_TIMEOUT_EN
  ,
  parameter int ACK_TIMEOUT  = 4095
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             aud_req,
  input  logic [LBA_W-1:0] aud_lba,
  output logic             aud_gnt,
  output logic             aud_ack,
  output logic             aud_wr,
  output logic             aud_done,
  input  logic             dat_req,
  input  logic [LBA_W-1:0] dat_lba,
  output logic             dat_gnt,
  output logic             dat_ack,
  output logic             dat_wr,
  output logic             dat_done,
  input  logic [11:0]      audio_fifo_usedw,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  input  logic             sd_ack,
  input  logic             sd_buff_wr,
  output logic [8:0]       xfer_words,
  output logic             short_xfer
`ifdef MSU_ARB_TIMEOUT_EN
  ,
  output logic             arb_timeout
`endif
);
  arb_state_t state;
  logic       owner;
  logic       rr_last;
  logic       winner;
  logic       aud_urgent;
  logic [8:0] word_cnt;
  logic       xfer_phase;

`ifdef MSU_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  assign aud_urgent = int'(audio_fifo_usedw) < AUD_LOW_WM;

  msu_rr_pick u_pick (
    .reqs   ({dat_req, aud_req}),
    .urgent (aud_urgent),
    .last   (rr_last),
    .winner (winner)
  );

  // HPS strobes reach only the owner, and only while the sector is streaming.
  assign xfer_phase = (state == ST_XFER);
  assign aud_ack    = xfer_phase && (owner == OWN_AUD) && sd_ack;
  assign aud_wr     = xfer_phase && (owner == OWN_AUD) && sd_buff_wr;
  assign dat_ack    = xfer_phase && (owner == OWN_DAT) && sd_ack;
  assign dat_wr     = xfer_phase && (owner == OWN_DAT) && sd_buff_wr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_AUD;
      rr_last    <= OWN_AUD;  // data goes first after reset
      sd_lba     <= '0;
      sd_rd      <= 1'b0;
      aud_gnt    <= 1'b0;
      dat_gnt    <= 1'b0;
      aud_done   <= 1'b0;
      dat_done   <= 1'b0;
      word_cnt   <= '0;
      xfer_words <= '0;
      short_xfer <= 1'b0;
`ifdef MSU_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      arb_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // A high sd_ack here is left over from an aborted transfer: wait it out.
          if (!sd_ack && (aud_req || dat_req)) begin
            owner   <= winner;
            sd_lba  <= (winner == OWN_AUD) ? aud_lba : dat_lba;
            sd_rd   <= 1'b1;
            aud_gnt <= (winner == OWN_AUD);
            dat_gnt <= (winner == OWN_DAT);
`ifdef MSU_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sd_ack) begin
            sd_rd    <= 1'b0;
            word_cnt <= '0;
            state    <= ST_XFER;
          end
`ifdef MSU_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
            // sd_rd was high for exactly ACK_TIMEOUT cycles
            sd_rd       <= 1'b0;
            aud_gnt     <= 1'b0;
            dat_gnt     <= 1'b0;
            aud_done    <= (owner == OWN_AUD);
            dat_done    <= (owner == OWN_DAT);
            arb_timeout <= 1'b1;
            short_xfer  <= 1'b1;
            state       <= ST_TMO;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_XFER: begin
          if (!sd_ack) begin
            xfer_words <= word_cnt;
            if (word_cnt != 9'(SECTOR_WORDS))
              short_xfer <= 1'b1;
            aud_gnt  <= 1'b0;
            dat_gnt  <= 1'b0;
            aud_done <= (owner == OWN_AUD);
            dat_done <= (owner == OWN_DAT);
            state    <= ST_DONE;
          end else if (sd_buff_wr && word_cnt != 9'h1FF) begin
            word_cnt <= word_cnt + 9'd1;
          end
        end
        ST_DONE: begin
          aud_done <= 1'b0;
          dat_done <= 1'b0;
          rr_last  <= owner;
          state    <= ST_IDLE;
        end
`ifdef MSU_ARB_TIMEOUT_EN
        ST_TMO: begin
          aud_done    <= 1'b0;
          dat_done    <= 1'b0;
          arb_timeout <= 1'b0;
          rr_last     <= owner;
          state       <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msu_sd_arbiter.sv
// tb_msu_sd_arbiter: scenario tasks driving msu_sd_arbiter with randomized
// HPS timing and requests; expectations come from the arbitration rules
// (urgent audio, single requester, alternate) and simple word arithmetic.
module tb_msu_sd_arbiter;
  localparam int LBA_W = 21;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             aud_req = 1'b0, dat_req = 1'b0;
  logic [LBA_W-1:0] aud_lba = '0, dat_lba = '0;
  logic             aud_gnt, aud_ack, aud_wr, aud_done;
  logic             dat_gnt, dat_ack, dat_wr, dat_done;
  logic [11:0]      usedw = '0;
  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd;
  logic             sd_ack = 1'b0, sd_buff_wr = 1'b0;
  logic [8:0]       xfer_words;
  logic             short_xfer;
`ifdef MSU_ARB_TIMEOUT_EN
  logic             arb_timeout;
`endif

  int n_cmp = 0, n_err = 0;
  int wa, wd, da, dd, excl = 0;

  always #5 clk = ~clk;

`ifdef MSU_ARB_TIMEOUT_EN
  msu_sd_arbiter #(.ACK_TIMEOUT(16)) dut (
`else
  msu_sd_arbiter dut (
`endif
    .clk(clk), .reset_n(reset_n),
    .aud_req(aud_req), .aud_lba(aud_lba), .aud_gnt(aud_gnt), .aud_ack(aud_ack),
    .aud_wr(aud_wr), .aud_done(aud_done),
    .dat_req(dat_req), .dat_lba(dat_lba), .dat_gnt(dat_gnt), .dat_ack(dat_ack),
    .dat_wr(dat_wr), .dat_done(dat_done),
    .audio_fifo_usedw(usedw), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .xfer_words(xfer_words), .short_xfer(short_xfer)
`ifdef MSU_ARB_TIMEOUT_EN
    , .arb_timeout(arb_timeout)
`endif
  );

  // One cycle: sample at negedge, track routing/done, requesters drop req on done.
  task automatic step;
    @(negedge clk);
    if (aud_wr) wa++;
    if (dat_wr) wd++;
    if (aud_done) begin da++; aud_req = 1'b0; end
    if (dat_done) begin dd++; dat_req = 1'b0; end
    if (aud_gnt && dat_gnt) excl++;
    if ((aud_ack && !aud_gnt) || (dat_ack && !dat_gnt)) excl++;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0; aud_req = 1'b0; dat_req = 1'b0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    step; step;
    reset_n = 1'b1;
  endtask

  // HPS side of one sector: wait for sd_rd, ack, deliver nwr strobes, drop ack,
  // then run through DONE back to IDLE.
  task automatic do_sector(input int nwr, output int own,
                           output logic [LBA_W-1:0] lba, output int lat);
    wa = 0; wd = 0; da = 0; dd = 0; lat = 0; own = -1; lba = '0;
    while (!sd_rd && lat < 20) begin step; lat++; end
    n_cmp++;
    if (!sd_rd) begin
      n_err++;
      $display("FAIL sd_rd_wait: sd_rd still 0 after %0d cycles, required 1", lat);
      return;
    end
    own = dat_gnt ? 1 : (aud_gnt ? 0 : -1);
    lba = sd_lba;
    // requester scribbles its lba while granted; sd_lba must not follow
    if (own == 0) aud_lba = LBA_W'($urandom); else dat_lba = LBA_W'($urandom);
    repeat ($urandom_range(0, 2)) step;
    sd_ack = 1'b1; step;
    for (int i = 0; i < nwr; i++) begin
      if ($urandom_range(0, 3) == 0) begin sd_buff_wr = 1'b0; step; end
      sd_buff_wr = 1'b1; step;
    end
    sd_buff_wr = 1'b0;
    n_cmp++;
    if (sd_lba !== lba) begin
      n_err++;
      $display("FAIL lba_latched: sd_lba=%0d required %0d", sd_lba, lba);
    end
    sd_ack = 1'b0; step; step;
  endtask

  task automatic test_reset;
    apply_reset;
    n_cmp++;
    if ({sd_rd, aud_gnt, dat_gnt, aud_done, dat_done, aud_ack, aud_wr, dat_ack, dat_wr, short_xfer} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: outputs=%b required 0", {sd_rd, aud_gnt, dat_gnt, aud_done, dat_done, aud_ack, aud_wr, dat_ack, dat_wr, short_xfer});
    end
    n_cmp++;
    if (sd_lba !== '0 || xfer_words !== 9'd0) begin
      n_err++;
      $display("FAIL reset_data: sd_lba=%0d xfer_words=%0d required 0/0", sd_lba, xfer_words);
    end
  endtask

  task automatic test_audio_only;
    int own, lat; logic [LBA_W-1:0] lba;
    apply_reset;
    usedw = 12'd2000; aud_lba = 21'd5; aud_req = 1'b1;
    do_sector(256, own, lba, lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL aud_latency: %0d cycles, required 1", lat); end
    n_cmp++; if (lba !== 21'd5) begin n_err++; $display("FAIL aud_lba: sd_lba=%0d required 5", lba); end
    n_cmp++; if (own !== 0) begin n_err++; $display("FAIL aud_owner: owner=%0d required 0", own); end
    n_cmp++; if (wa !== 256 || wd !== 0) begin n_err++; $display("FAIL aud_routing: aud_wr=%0d dat_wr=%0d required 256/0", wa, wd); end
    n_cmp++; if (da !== 1 || dd !== 0) begin n_err++; $display("FAIL aud_done: aud=%0d dat=%0d required 1/0", da, dd); end
    n_cmp++; if (xfer_words !== 9'd256 || short_xfer !== 1'b0) begin n_err++; $display("FAIL aud_words: xfer_words=%0d short=%0b required 256/0", xfer_words, short_xfer); end
  endtask

  task automatic test_round_robin;
    int own, lat; logic [LBA_W-1:0] lba, la, ld;
    int exp_own [4] = '{1, 0, 1, 0};
    apply_reset;
    usedw = 12'd2000; excl = 0;
    for (int s = 0; s < 4; s++) begin
      if (!aud_req) begin aud_lba = LBA_W'($urandom); aud_req = 1'b1; end
      if (!dat_req) begin dat_lba = LBA_W'($urandom); dat_req = 1'b1; end
      la = aud_lba; ld = dat_lba;
      do_sector(256, own, lba, lat);
      n_cmp++; if (own !== exp_own[s]) begin n_err++; $display("FAIL rr_owner[%0d]: owner=%0d required %0d", s, own, exp_own[s]); end
      n_cmp++; if (lba !== (exp_own[s] == 1 ? ld : la)) begin n_err++; $display("FAIL rr_lba[%0d]: sd_lba=%0d required %0d", s, lba, exp_own[s] == 1 ? ld : la); end
      n_cmp++;
      if ((exp_own[s] == 1 ? wd : wa) !== 256 || (exp_own[s] == 1 ? (wa + da) : (wd + dd)) !== 0 || (exp_own[s] == 1 ? dd : da) !== 1) begin
        n_err++; $display("FAIL rr_route[%0d]: wa=%0d wd=%0d da=%0d dd=%0d", s, wa, wd, da, dd);
      end
    end
    n_cmp++; if (excl !== 0) begin n_err++; $display("FAIL rr_exclusive: %0d overlapping grant cycles, required 0", excl); end
  endtask

  task automatic test_urgent;
    int own, lat; logic [LBA_W-1:0] lba;
    int lvl [5] = '{1024, 500, 1023, 500, 1500};
    int exp_own [5] = '{1, 0, 0, 0, 1};
    apply_reset;
    for (int s = 0; s < 5; s++) begin
      usedw = 12'(lvl[s]);
      aud_req = 1'b1; dat_req = 1'b1;
      do_sector(256, own, lba, lat);
      n_cmp++; if (own !== exp_own[s]) begin n_err++; $display("FAIL urgent_owner[%0d] usedw=%0d: owner=%0d required %0d", s, lvl[s], own, exp_own[s]); end
    end
  endtask

  task automatic test_short;
    int own, lat; logic [LBA_W-1:0] lba;
    apply_reset;
    usedw = 12'd2000; aud_req = 1'b1;
    do_sector(100, own, lba, lat);
    n_cmp++; if (xfer_words !== 9'd100 || short_xfer !== 1'b1) begin n_err++; $display("FAIL short_words: xfer_words=%0d short=%0b required 100/1", xfer_words, short_xfer); end
    n_cmp++; if (da !== 1 || wa !== 100) begin n_err++; $display("FAIL short_done: done=%0d wr=%0d required 1/100", da, wa); end
    dat_req = 1'b1;
    do_sector(256, own, lba, lat);
    n_cmp++; if (own !== 1 || wd !== 256 || dd !== 1) begin n_err++; $display("FAIL short_next: owner=%0d wr=%0d done=%0d required 1/256/1", own, wd, dd); end
    n_cmp++; if (xfer_words !== 9'd256 || short_xfer !== 1'b1) begin n_err++; $display("FAIL short_sticky: xfer_words=%0d short=%0b required 256/1", xfer_words, short_xfer); end
  endtask

  task automatic test_reset_mid;
    int own, lat, n, bad; logic [LBA_W-1:0] lba;
    apply_reset;
    usedw = 12'd2000; aud_req = 1'b1;
    n = 0;
    while (!sd_rd && n < 20) begin step; n++; end
    sd_ack = 1'b1; step;
    for (int i = 0; i < 40; i++) begin sd_buff_wr = 1'b1; step; end
    reset_n = 1'b0; aud_req = 1'b0; sd_buff_wr = 1'b0;
    step;
    n_cmp++;
    if ({sd_rd, aud_gnt, dat_gnt, aud_done, dat_done, aud_ack, aud_wr, dat_ack, dat_wr, short_xfer} !== 10'd0 || sd_lba !== '0 || xfer_words !== 9'd0) begin
      n_err++; $display("FAIL midreset_outputs: ctrl=%b sd_lba=%0d xfer_words=%0d required all 0",
        {sd_rd, aud_gnt, dat_gnt, aud_done, dat_done, aud_ack, aud_wr, dat_ack, dat_wr, short_xfer}, sd_lba, xfer_words);
    end
    reset_n = 1'b1; aud_req = 1'b1; bad = 0;
    for (int i = 0; i < 4; i++) begin step; if (sd_rd || aud_gnt || aud_ack) bad++; end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stale_ack: %0d cycles granted under stale sd_ack, required 0", bad); end
    sd_ack = 1'b0;
    do_sector(256, own, lba, lat);
    n_cmp++; if (lat !== 1 || own !== 0 || da !== 1) begin n_err++; $display("FAIL midreset_recover: lat=%0d owner=%0d done=%0d required 1/0/1", lat, own, da); end
    n_cmp++; if (xfer_words !== 9'd256 || short_xfer !== 1'b0) begin n_err++; $display("FAIL midreset_words: xfer_words=%0d short=%0b required 256/0", xfer_words, short_xfer); end
  endtask

  task automatic test_random;
    int own, lat, e, nwr, ew, r, last_m, short_m;
    logic [LBA_W-1:0] lba, la, ld;
    apply_reset;
    last_m = 0; short_m = 0;
    for (int s = 0; s < 10; s++) begin
      if (!aud_req && $urandom_range(0, 1) == 1) begin aud_lba = LBA_W'($urandom); aud_req = 1'b1; end
      if (!dat_req && $urandom_range(0, 1) == 1) begin dat_lba = LBA_W'($urandom); dat_req = 1'b1; end
      if (!aud_req && !dat_req) begin aud_lba = LBA_W'($urandom); aud_req = 1'b1; end
      r = $urandom_range(0, 3);
      usedw = (r == 1) ? 12'd1023 : (r == 2) ? 12'd1024 : 12'($urandom_range(0, 4095));
      r = $urandom_range(0, 9);
      nwr = (r == 0) ? 520 : (r < 5) ? 256 : $urandom_range(1, 300);
      if (aud_req && usedw < 12'd1024) e = 0;
      else if (aud_req && !dat_req) e = 0;
      else if (dat_req && !aud_req) e = 1;
      else e = 1 - last_m;
      ew = (nwr > 511) ? 511 : nwr;
      if (ew != 256) short_m = 1;
      la = aud_lba; ld = dat_lba;
      do_sector(nwr, own, lba, lat);
      n_cmp++; if (own !== e) begin n_err++; $display("FAIL rand_owner[%0d]: owner=%0d required %0d", s, own, e); end
      n_cmp++; if (lba !== (e == 1 ? ld : la)) begin n_err++; $display("FAIL rand_lba[%0d]: sd_lba=%0d required %0d", s, lba, e == 1 ? ld : la); end
      n_cmp++; if (xfer_words !== 9'(ew) || short_xfer !== short_m[0]) begin n_err++; $display("FAIL rand_words[%0d]: xfer_words=%0d short=%0b required %0d/%0d", s, xfer_words, short_xfer, ew, short_m); end
      n_cmp++; if ((e == 1 ? wd : wa) !== nwr || (e == 1 ? dd : da) !== 1) begin n_err++; $display("FAIL rand_route[%0d]: wa=%0d wd=%0d da=%0d dd=%0d required wr %0d done 1", s, wa, wd, da, dd, nwr); end
      last_m = e;
    end
  endtask

`ifdef MSU_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int n, hi;
    apply_reset;
    usedw = 12'd2000; aud_req = 1'b1; da = 0;
    n = 0;
    while (!sd_rd && n < 20) begin step; n++; end
    hi = 0;
    while (sd_rd && hi < 40) begin hi++; step; end
    n_cmp++; if (hi !== 16) begin n_err++; $display("FAIL tmo_rd_cycles: %0d, required 16", hi); end
    n_cmp++; if (arb_timeout !== 1'b1 || aud_done !== 1'b1) begin n_err++; $display("FAIL tmo_pulse: arb_timeout=%0b aud_done=%0b required 1/1", arb_timeout, aud_done); end
    step;
    n_cmp++; if (arb_timeout !== 1'b0 || aud_done !== 1'b0 || aud_gnt !== 1'b0 || short_xfer !== 1'b1) begin
      n_err++; $display("FAIL tmo_after: arb_timeout=%0b done=%0b gnt=%0b short=%0b required 0/0/0/1", arb_timeout, aud_done, aud_gnt, short_xfer);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_audio_only;
    test_round_robin;
    test_urgent;
    test_short;
    test_reset_mid;
    test_random;
`ifdef MSU_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
